// File: rtl/video_pkg.sv
// ---------------------------------------------------------------------------
// video_pkg: default raster timing, RST opcodes and IRQ state encoding.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package video_pkg;

   localparam int DEF_H_VISIBLE = 640;
   localparam int DEF_H_FRONT   = 16;
   localparam int DEF_H_SYNC    = 96;
   localparam int DEF_H_BACK    = 48;
   localparam int DEF_V_VISIBLE = 480;
   localparam int DEF_V_FRONT   = 10;
   localparam int DEF_V_SYNC    = 2;
   localparam int DEF_V_BACK    = 33;
   localparam int DEF_MID_LINE  = 240;

   localparam logic [7:0] RST1_OPCODE = 8'hCF;
   localparam logic [7:0] RST2_OPCODE = 8'hD7;

   typedef enum logic [0:0] {
      IRQ_IDLE    = 1'b0,
      IRQ_PENDING = 1'b1
   } irq_state_e;

   function automatic int h_total(input int vis, input int fp, input int sw, input int bp);
      return vis + fp + sw + bp;
   endfunction

   function automatic int v_total(input int vis, input int fp, input int sw, input int bp);
      return vis + fp + sw + bp;
   endfunction

endpackage

`default_nettype wire

// File: rtl/irq_arbiter.sv
// ---------------------------------------------------------------------------
// irq_arbiter: IDLE/PENDING interrupt handshake toward the 8080 core.
// Optional saturating overrun counter under IRQ_OVERRUN_CNT_EN. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module irq_arbiter
   import video_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       mid_i,
   input  logic       vbl_i,
   input  logic       irq_ack_i,
`ifdef IRQ_OVERRUN_CNT_EN
   output logic [7:0] irq_overrun_o,
`endif
   output logic       irq_req_o,
   output logic [7:0] irq_vector_o
);

   irq_state_e state_q;
   logic       req_q;
   logic [7:0] vector_q;
   logic       event_d;
   logic [7:0] event_vec_d;

   assign event_d     = mid_i | vbl_i;
   assign event_vec_d = mid_i ? RST1_OPCODE : RST2_OPCODE;

`ifdef IRQ_OVERRUN_CNT_EN
   logic [7:0] overrun_q;
   assign irq_overrun_o = overrun_q;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IRQ_IDLE;
         req_q    <= 1'b0;
         vector_q <= 8'h00;
`ifdef IRQ_OVERRUN_CNT_EN
         overrun_q <= 8'h00;
`endif
      end else begin
         case (state_q)
            IRQ_IDLE: begin
               if (event_d) begin
                  state_q  <= IRQ_PENDING;
                  req_q    <= 1'b1;
                  vector_q <= event_vec_d;
               end
            end
            IRQ_PENDING: begin
               // A new event always wins; without a matching ack the old request is lost.
               if (event_d) begin
                  vector_q <= event_vec_d;
`ifdef IRQ_OVERRUN_CNT_EN
                  if (!irq_ack_i && overrun_q != 8'hFF) begin
                     overrun_q <= overrun_q + 8'd1;
                  end
`endif
               end else if (irq_ack_i) begin
                  state_q <= IRQ_IDLE;
                  req_q   <= 1'b0;
               end
            end
            default: begin
               state_q <= IRQ_IDLE;
               req_q   <= 1'b0;
            end
         endcase
      end
   end

   assign irq_req_o    = req_q;
   assign irq_vector_o = vector_q;

endmodule

`default_nettype wire

// File: rtl/video_timing_irq.sv
// ---------------------------------------------------------------------------
// video_timing_irq: VGA raster counters/syncs plus RST 1 / RST 2 interrupts.
// Optional overrun counter port under IRQ_OVERRUN_CNT_EN. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module video_timing_irq
   import video_pkg::*;
#(
   parameter int H_VISIBLE       = DEF_H_VISIBLE,
   parameter int H_FRONT         = DEF_H_FRONT,
   parameter int H_SYNC          = DEF_H_SYNC,
   parameter int H_BACK          = DEF_H_BACK,
   parameter int V_VISIBLE       = DEF_V_VISIBLE,
   parameter int V_FRONT         = DEF_V_FRONT,
   parameter int V_SYNC          = DEF_V_SYNC,
   parameter int V_BACK          = DEF_V_BACK,
   parameter int MID_LINE        = DEF_MID_LINE,
   parameter bit SYNC_ACTIVE_LOW = 1'b1
) (
   input  logic       clk,
   input  logic       rst,
   output logic [9:0] x_o,
   output logic [9:0] y_o,
   output logic       hsync_o,
   output logic       vsync_o,
   output logic       active_o,
   output logic       frame_start_o,
   output logic       irq_req_o,
   output logic [7:0] irq_vector_o,
`ifdef IRQ_OVERRUN_CNT_EN
   output logic [7:0] irq_overrun_o,
`endif
   input  logic       irq_ack_i
);

   localparam int         H_TOTAL   = h_total(H_VISIBLE, H_FRONT, H_SYNC, H_BACK);
   localparam int         V_TOTAL   = v_total(V_VISIBLE, V_FRONT, V_SYNC, V_BACK);
   localparam logic [9:0] X_LAST    = 10'(H_TOTAL - 1);
   localparam logic [9:0] Y_LAST    = 10'(V_TOTAL - 1);
   localparam logic [9:0] X_VIS     = 10'(H_VISIBLE);
   localparam logic [9:0] Y_VIS     = 10'(V_VISIBLE);
   localparam logic [9:0] HS_START  = 10'(H_VISIBLE + H_FRONT);
   localparam logic [9:0] HS_END    = 10'(H_VISIBLE + H_FRONT + H_SYNC);
   localparam logic [9:0] VS_START  = 10'(V_VISIBLE + V_FRONT);
   localparam logic [9:0] VS_END    = 10'(V_VISIBLE + V_FRONT + V_SYNC);
   localparam logic [9:0] Y_MID     = 10'(MID_LINE);
   localparam logic       SYNC_ON   = ~SYNC_ACTIVE_LOW;
   localparam logic       SYNC_OFF  = SYNC_ACTIVE_LOW;

   generate
      if (MID_LINE >= V_VISIBLE) begin : g_mid_line_check
         $error("MID_LINE must be below V_VISIBLE");
      end
   endgenerate

   logic [9:0] x_q, y_q, x_d, y_d;
   logic       run_q;
   logic       hsync_q, vsync_q, active_q, frame_start_q;
   logic       mid_q, vbl_q;

   // The first edge after reset only arms the counters, so x=0,y=0 is shown decoded.
   always_comb begin
      x_d = x_q;
      y_d = y_q;
      if (run_q) begin
         if (x_q == X_LAST) begin
            x_d = '0;
            y_d = (y_q == Y_LAST) ? '0 : y_q + 10'd1;
         end else begin
            x_d = x_q + 10'd1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         x_q           <= '0;
         y_q           <= '0;
         run_q         <= 1'b0;
         hsync_q       <= SYNC_OFF;
         vsync_q       <= SYNC_OFF;
         active_q      <= 1'b0;
         frame_start_q <= 1'b0;
         mid_q         <= 1'b0;
         vbl_q         <= 1'b0;
      end else begin
         x_q           <= x_d;
         y_q           <= y_d;
         run_q         <= 1'b1;
         hsync_q       <= (x_d >= HS_START && x_d < HS_END) ? SYNC_ON : SYNC_OFF;
         vsync_q       <= (y_d >= VS_START && y_d < VS_END) ? SYNC_ON : SYNC_OFF;
         active_q      <= (x_d < X_VIS) && (y_d < Y_VIS);
         frame_start_q <= (x_d == '0) && (y_d == '0);
         mid_q         <= (x_d == '0) && (y_d == Y_MID);
         vbl_q         <= (x_d == '0) && (y_d == Y_VIS);
      end
   end

   irq_arbiter u_irq_arbiter (
      .clk          (clk),
      .rst          (rst),
      .mid_i        (mid_q),
      .vbl_i        (vbl_q),
      .irq_ack_i    (irq_ack_i),
`ifdef IRQ_OVERRUN_CNT_EN
      .irq_overrun_o(irq_overrun_o),
`endif
      .irq_req_o    (irq_req_o),
      .irq_vector_o (irq_vector_o)
   );

   assign x_o           = x_q;
   assign y_o           = y_q;
   assign hsync_o       = hsync_q;
   assign vsync_o       = vsync_q;
   assign active_o      = active_q;
   assign frame_start_o = frame_start_q;

endmodule

`default_nettype wire

// File: doc/video_timing_irq.md
Name: video_timing_irq

Overview:
- Downstream consumer of the divided pixel clock; runs entirely in that clock domain.
- Generates VGA raster timing: h/v counters, syncs and the active-video flag.
- Raises the two Space Invaders CPU interrupts with a request/acknowledge handshake toward the 8080 core:
  - mid-screen: RST 1, opcode 0xCF;
  - start of vblank: RST 2, opcode 0xD7.

Parameters:
- H_VISIBLE, 640, visible pixels per line
- H_FRONT, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync width (pixels)
- H_BACK, 48, horizontal back porch (pixels)
- V_VISIBLE, 480, visible lines per frame
- V_FRONT, 10, vertical front porch (lines)
- V_SYNC, 2, vsync width (lines)
- V_BACK, 33, vertical back porch (lines)
- MID_LINE, 240, line on which RST 1 fires
- SYNC_ACTIVE_LOW, 1, 1 = syncs asserted low

Ports:
- clk  in  1  divided pixel clock
- rst  in  1  synchronous active-high reset
- x  out  10  current horizontal count, 0..H_TOTAL-1
- y  out  10  current vertical count, 0..V_TOTAL-1
- hsync  out  1  horizontal sync (polarity per SYNC_ACTIVE_LOW)
- vsync  out  1  vertical sync
- active  out  1  high when x<H_VISIBLE and y<V_VISIBLE
- frame_start  out  1  one-cycle pulse at x=0,y=0
- irq_req  out  1  interrupt request, level, held until acknowledged
- irq_vector  out  8  RST opcode for the pending request
- irq_ack  in  1  one-cycle acknowledge from CPU

Behaviour:
- One clock, one domain: clk. Reset is synchronous and active-high, on rst.
- Timing totals:
  - H_TOTAL = sum of the four H parameters (800 at defaults).
  - V_TOTAL = sum of the four V parameters (525 at defaults).
- Counters:
  - x increments every clk; at H_TOTAL-1 it wraps to 0 and y increments.
  - y wraps from V_TOTAL-1 to 0 on the same cycle x wraps.
- Outputs:
  - All outputs are registered. hsync, vsync, active and frame_start are decoded from next-state counters, so they align with the x/y values in the same cycle. Zero latency between x/y and these outputs.
  - hsync is asserted for H_VISIBLE+H_FRONT <= x < H_VISIBLE+H_FRONT+H_SYNC (656..751).
  - vsync is asserted for V_VISIBLE+V_FRONT <= y < V_VISIBLE+V_FRONT+V_SYNC (490..491).
- Reset values:
  - x=0, y=0, active=0, frame_start=0.
  - hsync and vsync deasserted (1 when SYNC_ACTIVE_LOW=1).
  - irq_req=0, irq_vector=0x00.
  - The first cycle after reset release shows x=0, y=0, active=1, frame_start=1.
- IRQ events (each a single cycle):
  - MID: x=0, y=MID_LINE.
  - VBL: x=0, y=V_VISIBLE.
- IRQ state machine:
  - States: IDLE and PENDING.
  - IDLE --event--> PENDING: irq_req=1, irq_vector=0xCF for MID or 0xD7 for VBL, on the cycle after the event.
  - PENDING --irq_ack--> IDLE: irq_req=0 next cycle, irq_vector holds its last value.
  - PENDING --event, no ack--> PENDING with the new vector. The older request is dropped (overrun).
  - Event and irq_ack in the same cycle: the ack retires the old request and the new event is taken. Stay in PENDING with the new vector; irq_req never drops.
  - irq_ack in IDLE: ignored.
- rst mid-frame or with a pending request: everything returns to the reset values on the next edge and the pending request is discarded.
- Elaboration error if MID_LINE >= V_VISIBLE.

Optional Feature:
- Macro: IRQ_OVERRUN_CNT_EN.
- When defined:
  - Adds output port irq_overrun (8 bits): a saturating count of dropped requests, i.e. the PENDING+event-without-ack case.
  - Saturates at 0xFF. Cleared by rst only.
  - An event coinciding with an ack does not count.
- When undefined: the port and counter are absent; behaviour is otherwise identical.

Decomposition:
- Shared package video_pkg holds:
  - the default timing constants: H_/V_ values and the H_TOTAL/V_TOTAL functions;
  - RST opcodes RST1_OPCODE=8'hCF and RST2_OPCODE=8'hD7;
  - the IRQ state encoding.
- One natural sub-module, irq_arbiter: the IDLE/PENDING handshake, vector register and optional overrun counter. It is fed with one-cycle mid/vbl event strobes.
- Counter and sync decode stay in the top module.

Test Plan:
- Reset release: hold rst 3 cycles then release. First cycle x=0, y=0, frame_start=1, active=1. irq_req=0, hsync=1, vsync=1.
- Line timing: run 800 cycles. hsync low exactly for x=656..751 (96 cycles); active low from x=640. x wraps to 0 and y=1 at cycle 800.
- Frame timing: run 420000 cycles (one full frame of 800×525). vsync low for y=490..491 only; frame_start pulses once; y returns to 0.
- IRQ handshake: at y=240,x=0 expect irq_req=1, vector=0xCF the next cycle. Pulse irq_ack 5 cycles later; irq_req=0 next cycle. At y=480 expect vector=0xD7.
- Overrun: never ack MID. At y=480 irq_req stays 1 and vector becomes 0xD7; with IRQ_OVERRUN_CNT_EN, irq_overrun=1. An ack coinciding with the VBL event keeps irq_req=1 with 0xD7 and the count unchanged.
- Mid-operation reset: assert rst while PENDING at y=300. Next cycle irq_req=0, x=0, y=0, and irq_overrun=0 if enabled.
